// File: rtl/muldiv_defs_pkg.sv
// Shared encodings for the HI/LO multiply/divide controller: opcodes, FSM states
// and the divider step count.
package muldiv_defs;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   localparam int unsigned DIV_STEPS = 32;
   localparam int unsigned STEP_W    = $clog2(DIV_STEPS);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage

// File: rtl/div_iter.sv
// Restoring divider datapath: one quotient bit per step on unsigned operands.
// The remainder/quotient pair shifts left as a single register each step.
module div_iter
   import muldiv_defs::*;
#(
   parameter int unsigned DW = 32
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic          step,
   input  logic [DW-1:0] dividend,
   input  logic [DW-1:0] divisor,
   output logic [DW-1:0] quot,
   output logic [DW-1:0] rem,
   output logic          last
);

   logic [DW-1:0]     r_rem;
   logic [DW-1:0]     r_quot;
   logic [DW-1:0]     r_dvs;
   logic [STEP_W-1:0] r_cnt;

   logic [DW:0]       w_shift;
   logic [DW:0]       w_trial;
   logic              w_fit;

   // Shifted partial remainder is below 2*divisor, so a DW+1 bit subtract has
   // its MSB set exactly when the trial would go negative.
   assign w_shift = {r_rem, r_quot[DW-1]};
   assign w_trial = w_shift - {1'b0, r_dvs};
   assign w_fit   = ~w_trial[DW];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rem  <= '0;
         r_quot <= '0;
         r_dvs  <= '0;
         r_cnt  <= '0;
      end else if (load) begin
         r_rem  <= '0;
         r_quot <= dividend;
         r_dvs  <= divisor;
         r_cnt  <= '0;
      end else if (step) begin
         r_rem  <= w_fit ? w_trial[DW-1:0] : w_shift[DW-1:0];
         r_quot <= {r_quot[DW-2:0], w_fit};
         r_cnt  <= r_cnt + 1'b1;
      end
   end

   assign quot = r_quot;
   assign rem  = r_rem;
   assign last = (r_cnt == STEP_W'(DIV_STEPS - 1));

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU controller: stalls EX while the multiplier or
// divider runs, then issues one HI/LO write in the DONE cycle.
module muldiv_ctrl
   import muldiv_defs::*;
#(
   parameter int unsigned DW      = 32,
   parameter int unsigned MUL_LAT = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start_i,
   input  logic [1:0]    op_i,
   input  logic [DW-1:0] a_i,
   input  logic [DW-1:0] b_i,
   input  logic          flush_i,
   output logic          stall_o,
   output logic          hilo_we_o,
   output logic [DW-1:0] hi_o,
   output logic [DW-1:0] lo_o
);

   localparam int unsigned MCW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

   state_t          r_state;
   logic [1:0]      r_op;
   logic [DW-1:0]   r_a;
   logic [DW-1:0]   r_b;
   logic            r_neg_q;
   logic            r_neg_r;
   logic            r_dz;
   logic [MCW-1:0]  r_mul_cnt;
   logic [2*DW-1:0] r_prod;
   logic [DW-1:0]   r_hi;
   logic [DW-1:0]   r_lo;

   logic            w_signed_div;
   logic [DW-1:0]   w_abs_a;
   logic [DW-1:0]   w_abs_b;
   logic            w_load;
   logic            w_step;
   logic            w_last;
   logic [DW-1:0]   w_quot;
   logic [DW-1:0]   w_rem;
   logic            w_mul_signed;
   logic [2*DW-1:0] w_ext_a;
   logic [2*DW-1:0] w_ext_b;
   logic [2*DW-1:0] w_prod;
   logic [DW-1:0]   w_res_hi;
   logic [DW-1:0]   w_res_lo;
   logic            w_done;

   assign w_signed_div = (op_i == OP_DIV);
   assign w_abs_a      = (w_signed_div & a_i[DW-1]) ? -a_i : a_i;
   assign w_abs_b      = (w_signed_div & b_i[DW-1]) ? -b_i : b_i;
   assign w_load       = (r_state == IDLE) & start_i & ~flush_i & op_i[1] & (b_i != '0);
   assign w_step       = (r_state == DIV) & ~flush_i;

   div_iter #(
      .DW (DW)
   ) u_div_iter (
      .clk      (clk),
      .rst      (rst),
      .load     (w_load),
      .step     (w_step),
      .dividend (w_abs_a),
      .divisor  (w_abs_b),
      .quot     (w_quot),
      .rem      (w_rem),
      .last     (w_last)
   );

   // Sign-extending to 2*DW makes the truncated unsigned product correct for both
   // MULT and MULTU.
   assign w_mul_signed = (r_op == OP_MULT);
   assign w_ext_a      = {{DW{w_mul_signed & r_a[DW-1]}}, r_a};
   assign w_ext_b      = {{DW{w_mul_signed & r_b[DW-1]}}, r_b};
   assign w_prod       = w_ext_a * w_ext_b;

   always_comb begin
      w_res_hi = r_prod[2*DW-1:DW];
      w_res_lo = r_prod[DW-1:0];
      if (r_dz) begin
         w_res_hi = r_a;
         w_res_lo = '1;
      end else if (r_op[1]) begin
         w_res_lo = r_neg_q ? -w_quot : w_quot;
         w_res_hi = r_neg_r ? -w_rem : w_rem;
      end
   end

   assign w_done    = (r_state == DONE) & ~flush_i & ~rst;
   assign stall_o   = ~flush_i & ~rst &
                      (((r_state == IDLE) & start_i) | (r_state == MUL) | (r_state == DIV));
   assign hilo_we_o = w_done;
   assign hi_o      = w_done ? w_res_hi : r_hi;
   assign lo_o      = w_done ? w_res_lo : r_lo;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_op      <= OP_MULT;
         r_a       <= '0;
         r_b       <= '0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_dz      <= 1'b0;
         r_mul_cnt <= '0;
         r_prod    <= '0;
         r_hi      <= '0;
         r_lo      <= '0;
      end else if (flush_i) begin
         r_state   <= IDLE;
         r_mul_cnt <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               if (start_i) begin
                  r_op      <= op_i;
                  r_a       <= a_i;
                  r_b       <= b_i;
                  r_neg_q   <= w_signed_div & (a_i[DW-1] ^ b_i[DW-1]);
                  r_neg_r   <= w_signed_div & a_i[DW-1];
                  r_dz      <= op_i[1] & (b_i == '0);
                  r_mul_cnt <= '0;
                  if (!op_i[1]) begin
                     r_state <= MUL;
                  end else if (b_i == '0) begin
                     r_state <= DONE;
                  end else begin
                     r_state <= DIV;
                  end
               end
            end
            MUL: begin
               r_prod <= w_prod;
               if (r_mul_cnt == MCW'(MUL_LAT - 1)) begin
                  r_state <= DONE;
               end else begin
                  r_mul_cnt <= r_mul_cnt + 1'b1;
               end
            end
            DIV: begin
               if (w_last) begin
                  r_state <= DONE;
               end
            end
            DONE: begin
               // start_i here belongs to the instruction leaving EX, so it is ignored.
               r_hi    <= w_res_hi;
               r_lo    <= w_res_lo;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
